// File: rtl/ecc_16_dec_pipe.sv
// Read-side SECDED checker for {parity[5:0], data[15:0]} words.
// Two-stage valid/ready pipeline (syndrome, then correct/classify) with error statistics.
module ecc_16_dec_pipe #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bypass,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       in_data,
    input  logic [5:0]        in_parity,
    input  logic [ADDR_W-1:0] in_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_sbit,
    output logic              out_dbit,
    input  logic              clr_err,
    output logic [CNT_W-1:0]  sbit_cnt,
    output logic [CNT_W-1:0]  dbit_cnt,
    output logic              first_err_vld,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic              dbit_sticky
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Same parity equations as the write-side encoder
    function automatic logic [5:0] encode(input logic [15:0] d);
        logic [5:0] p;
        p[0] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6] ^ d[8] ^ d[10] ^ d[11] ^ d[13] ^ d[15];
        p[1] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6] ^ d[9] ^ d[10] ^ d[12] ^ d[13];
        p[2] = d[1] ^ d[2] ^ d[3] ^ d[7] ^ d[8] ^ d[9] ^ d[10] ^ d[14] ^ d[15];
        p[3] = ^d[10:4];
        p[4] = ^d[15:11];
        p[5] = d[0] ^ d[1] ^ d[2] ^ d[4] ^ d[5] ^ d[7] ^ d[10] ^ d[11] ^ d[12] ^ d[14];
        return p;
    endfunction

    logic              s1_full;
    logic [15:0]       s1_data;
    logic [5:0]        s1_syn;
    logic [ADDR_W-1:0] s1_addr;

    logic              s2_open_c;
    logic              s1_moves_c;
    logic              out_xfer_c;
    logic [15:0]       fix_data_c;
    logic              col_hit_c;
    logic              sbit_c;
    logic              dbit_c;

    assign s2_open_c  = !out_valid || out_ready;
    assign s1_moves_c = s1_full && s2_open_c;
    assign in_ready   = !s1_full || s1_moves_c;
    assign out_xfer_c = out_valid && out_ready;

    // S1: syndrome stage
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_full <= 1'b0;
            s1_data <= '0;
            s1_syn  <= '0;
            s1_addr <= '0;
        end else if (in_ready) begin
            s1_full <= in_valid;
            if (in_valid) begin
                s1_data <= in_data;
                s1_syn  <= in_parity ^ encode(in_data);
                s1_addr <= in_addr;
            end
        end
    end

    // Match the syndrome against each data column; a match flips that bit
    always_comb begin
        fix_data_c = s1_data;
        col_hit_c  = 1'b0;
        sbit_c     = 1'b0;
        dbit_c     = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (s1_syn == encode(16'(1) << i)) begin
                fix_data_c[i] = ~s1_data[i];
                col_hit_c     = 1'b1;
            end
        end
        if (bypass || s1_syn == 6'd0) begin
            fix_data_c = s1_data;
        end else if (col_hit_c) begin
            sbit_c = 1'b1;
        end else if ($onehot(s1_syn)) begin
            sbit_c     = 1'b1;
            fix_data_c = s1_data;
        end else begin
            dbit_c     = 1'b1;
            fix_data_c = s1_data;
        end
    end

    // S2: corrected output stage, holds while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
            out_sbit  <= 1'b0;
            out_dbit  <= 1'b0;
        end else if (s2_open_c) begin
            out_valid <= s1_full;
            if (s1_full) begin
                out_data <= fix_data_c;
                out_addr <= s1_addr;
                out_sbit <= sbit_c;
                out_dbit <= dbit_c;
            end
        end
    end

    // Statistics advance only on accepted output words; a clear pulse wins
    always_ff @(posedge clk) begin
        if (rst || clr_err) begin
            sbit_cnt       <= '0;
            dbit_cnt       <= '0;
            first_err_vld  <= 1'b0;
            first_err_addr <= '0;
            dbit_sticky    <= 1'b0;
        end else if (out_xfer_c) begin
            if (out_sbit && sbit_cnt != CNT_MAX) begin
                sbit_cnt <= sbit_cnt + CNT_W'(1);
            end
            if (out_dbit && dbit_cnt != CNT_MAX) begin
                dbit_cnt <= dbit_cnt + CNT_W'(1);
            end
            if (out_dbit) begin
                dbit_sticky <= 1'b1;
            end
            if ((out_sbit || out_dbit) && !first_err_vld) begin
                first_err_vld  <= 1'b1;
                first_err_addr <= out_addr;
            end
        end
    end

endmodule

// File: tb/tb_ecc_16_dec_pipe.sv
// Bench for ecc_16_dec_pipe: directed scenarios plus randomized streaming against
// a brute-force bit-flip reference model and a queue scoreboard.
module tb_ecc_16_dec_pipe;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned CNT_W  = 2;
    localparam int unsigned CMAX   = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst, bypass, in_valid, in_ready, out_valid, out_ready;
    logic              out_sbit, out_dbit, clr_err, first_err_vld, dbit_sticky;
    logic [15:0]       in_data, out_data;
    logic [5:0]        in_parity;
    logic [ADDR_W-1:0] in_addr, out_addr, first_err_addr;
    logic [CNT_W-1:0]  sbit_cnt, dbit_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ecc_16_dec_pipe #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .bypass(bypass),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_parity(in_parity), .in_addr(in_addr),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_addr(out_addr), .out_sbit(out_sbit), .out_dbit(out_dbit),
        .clr_err(clr_err), .sbit_cnt(sbit_cnt), .dbit_cnt(dbit_cnt),
        .first_err_vld(first_err_vld), .first_err_addr(first_err_addr),
        .dbit_sticky(dbit_sticky)
    );

    typedef struct packed {
        logic [15:0]       data;
        logic [ADDR_W-1:0] addr;
        logic              sbit;
        logic              dbit;
    } exp_t;

    exp_t exp_q[$];
    exp_t front;
    logic in_x, out_x, had, got_valid, got_sbit, got_dbit;
    logic [15:0] got_data;
    logic [ADDR_W-1:0] got_addr;

    int m_s, m_d;
    logic m_fv, m_st;
    logic [ADDR_W-1:0] m_fa;

    function automatic logic [5:0] enc(input logic [15:0] d);
        logic [5:0] p;
        p[0] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6] ^ d[8] ^ d[10] ^ d[11] ^ d[13] ^ d[15];
        p[1] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6] ^ d[9] ^ d[10] ^ d[12] ^ d[13];
        p[2] = d[1] ^ d[2] ^ d[3] ^ d[7] ^ d[8] ^ d[9] ^ d[10] ^ d[14] ^ d[15];
        p[3] = ^d[10:4];
        p[4] = ^d[15:11];
        p[5] = d[0] ^ d[1] ^ d[2] ^ d[4] ^ d[5] ^ d[7] ^ d[10] ^ d[11] ^ d[12] ^ d[14];
        return p;
    endfunction

    // Reference: search for a single flipped data or parity bit that makes the word consistent
    function automatic exp_t model(input logic [15:0] d, input logic [5:0] p,
                                   input logic [ADDR_W-1:0] a, input logic byp);
        exp_t r;
        logic [15:0] dd;
        r.data = d; r.addr = a; r.sbit = 1'b0; r.dbit = 1'b0;
        if (byp || enc(d) == p) return r;
        for (int i = 0; i < 16; i++) begin
            dd = d ^ (16'(1) << i);
            if (enc(dd) == p) begin
                r.data = dd; r.sbit = 1'b1;
                return r;
            end
        end
        for (int k = 0; k < 6; k++) begin
            if (enc(d) == (p ^ (6'(1) << k))) begin
                r.sbit = 1'b1;
                return r;
            end
        end
        r.dbit = 1'b1;
        return r;
    endfunction

    task automatic model_clear();
        m_s = 0; m_d = 0; m_fv = 1'b0; m_st = 1'b0; m_fa = '0;
    endtask

    task automatic model_count(input exp_t e);
        if (e.sbit && m_s < int'(CMAX)) m_s++;
        if (e.dbit && m_d < int'(CMAX)) m_d++;
        if (e.dbit) m_st = 1'b1;
        if ((e.sbit || e.dbit) && !m_fv) begin
            m_fv = 1'b1; m_fa = e.addr;
        end
    endtask

    // One clock: drive, sample pre-edge handshake and outputs, update scoreboard, advance
    task automatic step(input logic v, input logic [15:0] d, input logic [5:0] p,
                        input logic [ADDR_W-1:0] a, input logic ordy, input logic clr);
        in_valid = v; in_data = d; in_parity = p; in_addr = a; out_ready = ordy; clr_err = clr;
        #1;
        in_x = in_valid && in_ready;
        out_x = out_valid && out_ready;
        got_valid = out_valid; got_data = out_data; got_addr = out_addr;
        got_sbit = out_sbit; got_dbit = out_dbit;
        had = exp_q.size() > 0;
        if (had) front = exp_q[0];
        if (out_x && had) void'(exp_q.pop_front());
        if (in_x) exp_q.push_back(model(d, p, a, bypass));
        if (clr) model_clear();
        else if (out_x && had) model_count(front);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, 6'h0, '0, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; clr_err = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        model_clear();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 16'h0 || out_sbit !== 1'b0 ||
            out_dbit !== 1'b0) begin
            failures++;
            $display("FAIL reset_pipe out_valid=%b in_ready=%b out_data=%h sbit=%b dbit=%b (want 0 1 0000 0 0)",
                     out_valid, in_ready, out_data, out_sbit, out_dbit);
        end
        checks++;
        if (sbit_cnt !== '0 || dbit_cnt !== '0 || first_err_vld !== 1'b0 || first_err_addr !== '0 ||
            dbit_sticky !== 1'b0) begin
            failures++;
            $display("FAIL reset_stats sbit_cnt=%0d dbit_cnt=%0d fvld=%b faddr=%h sticky=%b (want all 0)",
                     sbit_cnt, dbit_cnt, first_err_vld, first_err_addr, dbit_sticky);
        end
    endtask

    task automatic test_clean();
        step(1'b1, 16'hA5C3, enc(16'hA5C3), 8'h11, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL clean_latency1 out_valid=%b want 0", out_valid);
        end
        idle(1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'hA5C3 || out_addr !== 8'h11 ||
            out_sbit !== 1'b0 || out_dbit !== 1'b0) begin
            failures++;
            $display("FAIL clean_out valid=%b data=%h addr=%h s=%b d=%b want 1 a5c3 11 0 0",
                     out_valid, out_data, out_addr, out_sbit, out_dbit);
        end
        idle(1);
        checks++;
        if (out_valid !== 1'b0 || sbit_cnt !== '0 || first_err_vld !== 1'b0) begin
            failures++;
            $display("FAIL clean_after valid=%b sbit_cnt=%0d fvld=%b want 0 0 0", out_valid, sbit_cnt, first_err_vld);
        end
    endtask

    task automatic test_sbit_data();
        step(1'b1, 16'h0008, 6'h00, 8'h5A, 1'b1, 1'b0);
        idle(1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h0000 || out_addr !== 8'h5A ||
            out_sbit !== 1'b1 || out_dbit !== 1'b0) begin
            failures++;
            $display("FAIL sbit_data_out valid=%b data=%h addr=%h s=%b d=%b want 1 0000 5a 1 0",
                     out_valid, out_data, out_addr, out_sbit, out_dbit);
        end
        idle(1);
        checks++;
        if (sbit_cnt !== 2'd1 || first_err_vld !== 1'b1 || first_err_addr !== 8'h5A || dbit_sticky !== 1'b0) begin
            failures++;
            $display("FAIL sbit_data_stats sbit_cnt=%0d fvld=%b faddr=%h sticky=%b want 1 1 5a 0",
                     sbit_cnt, first_err_vld, first_err_addr, dbit_sticky);
        end
    endtask

    task automatic test_parity_and_dbit();
        step(1'b1, 16'h0000, 6'b000001, 8'h21, 1'b1, 1'b0);
        step(1'b1, 16'h0003, 6'h00, 8'h22, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h0000 || out_sbit !== 1'b1 || out_dbit !== 1'b0) begin
            failures++;
            $display("FAIL parity_only valid=%b data=%h s=%b d=%b want 1 0000 1 0",
                     out_valid, out_data, out_sbit, out_dbit);
        end
        idle(1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h0003 || out_addr !== 8'h22 ||
            out_sbit !== 1'b0 || out_dbit !== 1'b1) begin
            failures++;
            $display("FAIL double_out valid=%b data=%h addr=%h s=%b d=%b want 1 0003 22 0 1",
                     out_valid, out_data, out_addr, out_sbit, out_dbit);
        end
        idle(1);
        checks++;
        if (dbit_cnt !== 2'd1 || dbit_sticky !== 1'b1 || sbit_cnt !== 2'd2 || first_err_addr !== 8'h5A) begin
            failures++;
            $display("FAIL double_stats dbit_cnt=%0d sticky=%b sbit_cnt=%0d faddr=%h want 1 1 2 5a",
                     dbit_cnt, dbit_sticky, sbit_cnt, first_err_addr);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] wd [0:4];
        logic [5:0]  wp [0:4];
        int idx = 0;
        int outs = 0;
        for (int k = 0; k < 5; k++) begin
            wd[k] = 16'($urandom);
            wp[k] = enc(wd[k]) ^ ((k == 1) ? 6'b000100 : 6'b000000);
        end
        for (int c = 0; c < 5; c++) begin
            step(idx < 4, wd[idx], wp[idx], 8'(8'h40 + idx), 1'b0, 1'b0);
            if (in_x) idx++;
            if (got_valid) begin
                checks++;
                if (!had || got_data !== front.data || got_addr !== front.addr || got_sbit !== front.sbit) begin
                    failures++;
                    $display("FAIL stall_hold cyc=%0d data=%h/%h addr=%h/%h sbit=%b/%b",
                             c, got_data, front.data, got_addr, front.addr, got_sbit, front.sbit);
                end
            end
        end
        checks++;
        if (idx != 2 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL stall_accept accepted=%0d in_ready=%b out_valid=%b want 2 0 1", idx, in_ready, out_valid);
        end
        for (int c = 0; c < 12; c++) begin
            step(idx < 4, wd[idx], wp[idx], 8'(8'h40 + idx), 1'b1, 1'b0);
            if (in_x) idx++;
            if (out_x) begin
                checks++;
                if (!had || got_data !== front.data || got_addr !== 8'(8'h40 + outs) || got_sbit !== front.sbit) begin
                    failures++;
                    $display("FAIL drain_order n=%0d data=%h/%h addr=%h/%h sbit=%b/%b",
                             outs, got_data, front.data, got_addr, 8'(8'h40 + outs), got_sbit, front.sbit);
                end
                outs++;
            end
        end
        checks++;
        if (outs != 4 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_count outs=%0d pending=%0d want 4 0", outs, exp_q.size());
        end
    endtask

    task automatic test_saturation_clear();
        logic [15:0] d;
        step(1'b0, 16'h0, 6'h0, '0, 1'b1, 1'b1);
        checks++;
        if (sbit_cnt !== '0 || dbit_cnt !== '0 || first_err_vld !== 1'b0 || dbit_sticky !== 1'b0) begin
            failures++;
            $display("FAIL clr_idle sbit=%0d dbit=%0d fvld=%b sticky=%b want 0", sbit_cnt, dbit_cnt,
                     first_err_vld, dbit_sticky);
        end
        for (int k = 0; k < 5; k++) begin
            d = 16'($urandom);
            step(1'b1, d ^ (16'(1) << $urandom_range(0, 15)), enc(d), 8'(8'h70 + k), 1'b1, 1'b0);
        end
        idle(3);
        checks++;
        if (sbit_cnt !== 2'd3 || sbit_cnt !== CNT_W'(m_s) || first_err_addr !== 8'h70) begin
            failures++;
            $display("FAIL sat_count sbit_cnt=%0d faddr=%h want 3 70", sbit_cnt, first_err_addr);
        end
        d = 16'hBEEF;
        step(1'b1, d ^ 16'h0100, enc(d), 8'h7F, 1'b1, 1'b0);
        idle(1);
        step(1'b0, 16'h0, 6'h0, '0, 1'b1, 1'b1);
        checks++;
        if (out_x !== 1'b1 || got_sbit !== 1'b1 || sbit_cnt !== '0 || first_err_vld !== 1'b0) begin
            failures++;
            $display("FAIL clr_wins xfer=%b sbit=%b sbit_cnt=%0d fvld=%b want 1 1 0 0",
                     out_x, got_sbit, sbit_cnt, first_err_vld);
        end
    endtask

    task automatic test_random();
        logic [15:0] d;
        logic [5:0]  p;
        logic [21:0] w;
        int i, j, kind;
        for (int c = 0; c < 400; c++) begin
            d = 16'($urandom);
            p = enc(d);
            kind = $urandom_range(0, 3);
            w = {p, d};
            if (kind == 1) w[$urandom_range(0, 15)] ^= 1'b1;
            else if (kind == 2) w[$urandom_range(16, 21)] ^= 1'b1;
            else if (kind == 3) begin
                i = $urandom_range(0, 21);
                j = (i + $urandom_range(1, 21)) % 22;
                w[i] ^= 1'b1;
                w[j] ^= 1'b1;
            end
            step($urandom_range(0, 3) != 0, w[15:0], w[21:16], 8'($urandom), $urandom_range(0, 9) < 7,
                 $urandom_range(0, 29) == 0);
            if (got_valid) begin
                checks++;
                if (!had || got_data !== front.data || got_addr !== front.addr ||
                    got_sbit !== front.sbit || got_dbit !== front.dbit) begin
                    failures++;
                    $display("FAIL rand_out cyc=%0d data=%h/%h addr=%h/%h s=%b/%b d=%b/%b", c,
                             got_data, front.data, got_addr, front.addr, got_sbit, front.sbit, got_dbit, front.dbit);
                end
            end
            checks++;
            if (sbit_cnt !== CNT_W'(m_s) || dbit_cnt !== CNT_W'(m_d) || first_err_vld !== m_fv ||
                dbit_sticky !== m_st || (m_fv && first_err_addr !== m_fa)) begin
                failures++;
                $display("FAIL rand_stats cyc=%0d s=%0d/%0d d=%0d/%0d fvld=%b/%b sticky=%b/%b faddr=%h/%h", c,
                         sbit_cnt, m_s, dbit_cnt, m_d, first_err_vld, m_fv, dbit_sticky, m_st, first_err_addr, m_fa);
            end
        end
        for (int c = 0; c < 10; c++) begin
            step(1'b0, 16'h0, 6'h0, '0, 1'b1, 1'b0);
            if (got_valid) begin
                checks++;
                if (!had || got_data !== front.data || got_dbit !== front.dbit || got_sbit !== front.sbit) begin
                    failures++;
                    $display("FAIL rand_drain data=%h/%h s=%b/%b d=%b/%b", got_data, front.data,
                             got_sbit, front.sbit, got_dbit, front.dbit);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rand_empty pending=%0d out_valid=%b want 0 0", exp_q.size(), out_valid);
        end
    endtask

    task automatic test_bypass_reset();
        int s0, d0;
        s0 = m_s; d0 = m_d;
        bypass = 1'b1;
        step(1'b1, 16'h0008, 6'h00, 8'h33, 1'b1, 1'b0);
        idle(1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h0008 || out_sbit !== 1'b0 || out_dbit !== 1'b0) begin
            failures++;
            $display("FAIL bypass_out valid=%b data=%h s=%b d=%b want 1 0008 0 0",
                     out_valid, out_data, out_sbit, out_dbit);
        end
        idle(1);
        checks++;
        if (sbit_cnt !== CNT_W'(s0) || dbit_cnt !== CNT_W'(d0)) begin
            failures++;
            $display("FAIL bypass_cnt sbit_cnt=%0d dbit_cnt=%0d want %0d %0d", sbit_cnt, dbit_cnt, s0, d0);
        end
        bypass = 1'b0;
        step(1'b1, 16'h1234, enc(16'h1234), 8'h01, 1'b1, 1'b0);
        step(1'b1, 16'h0003, 6'h00, 8'h02, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL midstream_pre out_valid=%b want 1", out_valid);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || dbit_cnt !== '0) begin
            failures++;
            $display("FAIL midstream_rst out_valid=%b in_ready=%b dbit_cnt=%0d want 0 1 0",
                     out_valid, in_ready, dbit_cnt);
        end
        rst = 1'b0;
        exp_q.delete();
        model_clear();
        idle(3);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL midstream_flush out_valid=%b want 0", out_valid);
        end
    endtask

    initial begin
        rst = 1'b1; bypass = 1'b0; in_valid = 1'b0; in_data = '0; in_parity = '0;
        in_addr = '0; out_ready = 1'b1; clr_err = 1'b0;
        model_clear();
        test_reset();
        test_clean();
        test_sbit_data();
        test_parity_and_dbit();
        test_back_to_back();
        test_saturation_clear();
        test_random();
        test_bypass_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
